// File: rtl/vid_timing_out_if.sv
// Pixel FIFO read port seen by the video timing generator.
//
// Handshake: pix_in is the show-ahead head of the R/G/B FIFOs and is valid
// whenever fifo_empty is low. fifo_rd is the pop strobe. An entry is consumed
// at the rising clock edge where fifo_rd is high. fifo_rd is only raised while
// fifo_empty is low, so a pop never targets an empty FIFO.
interface vid_timing_out_if;
  logic        fifo_empty;
  logic [23:0] pix_in;
  logic        fifo_rd;

  // Timing generator side: it decides when to pop.
  modport master (
    input  fifo_empty,
    input  pix_in,
    output fifo_rd
  );

  // FIFO side: it supplies data and status.
  modport slave (
    output fifo_empty,
    output pix_in,
    input  fifo_rd
  );
endinterface

// File: rtl/vid_timing_out.sv
// Video timing generator and pixel output stage.
// It walks an (h,v) raster at one position per pixel tick and produces
// registered sync and blank signals for the next position. On displayed
// positions it pops one entry from the R/G/B FIFOs. The timing fields are
// shadowed, so a reprogramming only takes effect at a frame boundary.
module vid_timing_out #(
  parameter int CNT_W = 13,
  parameter int DIV_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] pcnt,
  input  logic [CNT_W-1:0] hend,
  input  logic [CNT_W-1:0] hsize,
  input  logic [CNT_W-1:0] hsync_start,
  input  logic [CNT_W-1:0] hsync_end,
  input  logic [CNT_W-1:0] vend,
  input  logic [CNT_W-1:0] vsize,
  input  logic [CNT_W-1:0] vsync_start,
  input  logic [CNT_W-1:0] vsync_end,
  vid_timing_out_if.master fifo,
  output logic             hsync,
  output logic             hblank,
  output logic             vsync,
  output logic             vblank,
  output logic [7:0]       R,
  output logic [7:0]       G,
  output logic [7:0]       B,
  output logic             line_start,
  output logic             frame_start,
  output logic             underflow,
  output logic             dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] h_q, v_q;

  logic [DIV_W-1:0] pcnt_sh_q;
  logic [CNT_W-1:0] hend_sh_q, hsize_sh_q, hss_sh_q, hse_sh_q;
  logic [CNT_W-1:0] vend_sh_q, vsize_sh_q, vss_sh_q, vse_sh_q;

  logic             hsync_q, hblank_q, vsync_q, vblank_q;
  logic [23:0]      rgb_q;
  logic             line_start_q, frame_start_q, underflow_q;

  logic             run, tick, line_wrap, frame_wrap, disp;
  logic [CNT_W-1:0] h_last, v_last, h_next, v_next;
  logic [CNT_W-1:0] hsize_e, hss_e, hse_e, vsize_e, vss_e, vse_e;

  // Next-state logic: leave IDLE only with a usable (nonzero) geometry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en && (hend != '0) && (vend != '0)) state_d = S_RUN;
      S_RUN:   if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Raster position arithmetic and the pixel pop decision.
  always_comb begin
    run        = (state_q == S_RUN);
    tick       = run && en && (div_q == pcnt_sh_q);
    h_last     = (hend_sh_q == '0) ? '0 : hend_sh_q - CNT_W'(1);
    v_last     = (vend_sh_q == '0) ? '0 : vend_sh_q - CNT_W'(1);
    line_wrap  = (h_q == h_last);
    frame_wrap = line_wrap && (v_q == v_last);
    h_next     = line_wrap ? '0 : h_q + CNT_W'(1);
    v_next     = line_wrap ? ((v_q == v_last) ? '0 : v_q + CNT_W'(1)) : v_q;
    // On the tick that lands on (0,0) the shadows reload at the same edge,
    // so the first position of the new frame is judged with the new fields.
    hsize_e    = frame_wrap ? hsize       : hsize_sh_q;
    hss_e      = frame_wrap ? hsync_start : hss_sh_q;
    hse_e      = frame_wrap ? hsync_end   : hse_sh_q;
    vsize_e    = frame_wrap ? vsize       : vsize_sh_q;
    vss_e      = frame_wrap ? vsync_start : vss_sh_q;
    vse_e      = frame_wrap ? vsync_end   : vse_sh_q;
    disp       = tick && (h_next < hsize_e) && (v_next < vsize_e);
    fifo.fifo_rd = disp && !fifo.fifo_empty;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Pixel divider and raster position; IDLE parks on the last position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else if (!run) begin
      div_q <= '0;
      h_q   <= (hend == '0) ? '0 : hend - CNT_W'(1);
      v_q   <= (vend == '0) ? '0 : vend - CNT_W'(1);
    end else if (tick) begin
      div_q <= '0;
      h_q   <= h_next;
      v_q   <= v_next;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Shadow copies of the programmed fields, refreshed in IDLE and at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_sh_q  <= '0;
      hend_sh_q  <= '0;
      hsize_sh_q <= '0;
      hss_sh_q   <= '0;
      hse_sh_q   <= '0;
      vend_sh_q  <= '0;
      vsize_sh_q <= '0;
      vss_sh_q   <= '0;
      vse_sh_q   <= '0;
    end else if (!run || (tick && frame_wrap)) begin
      pcnt_sh_q  <= pcnt;
      hend_sh_q  <= hend;
      hsize_sh_q <= hsize;
      hss_sh_q   <= hsync_start;
      hse_sh_q   <= hsync_end;
      vend_sh_q  <= vend;
      vsize_sh_q <= vsize;
      vss_sh_q   <= vsync_start;
      vse_sh_q   <= vsync_end;
    end
  end

  // Registered timing and pixel outputs, updated for the next position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q       <= 1'b0;
      hblank_q      <= 1'b1;
      vsync_q       <= 1'b0;
      vblank_q      <= 1'b1;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (state_d == S_IDLE) begin
      hsync_q       <= 1'b0;
      hblank_q      <= 1'b1;
      vsync_q       <= 1'b0;
      vblank_q      <= 1'b1;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (tick) begin
      hblank_q      <= (h_next >= hsize_e);
      vblank_q      <= (v_next >= vsize_e);
      hsync_q       <= (h_next >= hss_e) && (h_next < hse_e);
      vsync_q       <= (v_next >= vss_e) && (v_next < vse_e);
      rgb_q         <= fifo.fifo_rd ? fifo.pix_in : 24'h0;
      line_start_q  <= (h_next == '0);
      frame_start_q <= (h_next == '0) && (v_next == '0);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  // Sticky underflow, cleared when a new run starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    underflow_q <= 1'b0;
    else if (!run && (state_d == S_RUN))          underflow_q <= 1'b0;
    else if (disp && fifo.fifo_empty)             underflow_q <= 1'b1;
  end

  assign hsync       = hsync_q;
  assign hblank      = hblank_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign R           = rgb_q[23:16];
  assign G           = rgb_q[15:8];
  assign B           = rgb_q[7:0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vid_timing_out.sv
// Bench for vid_timing_out: raster model derived from the tick index,
// FIFO pops scoreboarded through an expected-pixel queue.
module tb_vid_timing_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [5:0]  pcnt;
  logic [12:0] hend, hsize, hsync_start, hsync_end;
  logic [12:0] vend, vsize, vsync_start, vsync_end;
  logic        hsync, hblank, vsync, vblank;
  logic [7:0]  R, G, B;
  logic        line_start, frame_start, underflow, dbg_state;

  vid_timing_out_if fif ();

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  vid_timing_out #(.CNT_W(13), .DIV_W(6)) dut (
    .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
    .hend(hend), .hsize(hsize), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .vend(vend), .vsize(vsize), .vsync_start(vsync_start), .vsync_end(vsync_end),
    .fifo(fif.master),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(R), .G(G), .B(B),
    .line_start(line_start), .frame_start(frame_start),
    .underflow(underflow), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hblank"}, hblank, 1);
    chk({tag, "_vblank"}, vblank, 1);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_rgb"}, {R, G, B}, 0);
    chk({tag, "_fifo_rd"}, fif.fifo_rd, 0);
    chk({tag, "_pulses"}, {line_start, frame_start}, 0);
  endtask

  // Runs the raster from IDLE. Tick k lands on raster position k (mod frame).
  // hs_new is the hsize used from frame 1 on (input changed at (4,1)).
  task automatic run_cfg(input int pc, input int he, input int hs, input int hss,
                         input int hse, input int ve, input int vs, input int vss,
                         input int vse, input int hs_new, input int nframes,
                         input bit uf, input int abort_k);
    int p, total, m, k, q, f, h, v, qn, fn, hh, vv, hsz, hszn;
    int rd_cnt, fs_cnt;
    bit is_tick, act, act_n, nt, drv_empty, uf_flag, exp_rd;
    logic [23:0] exp_rgb;
    p = pc + 1;
    total = p * he * ve * nframes;
    rd_cnt = 0; fs_cnt = 0; uf_flag = 0; drv_empty = 0; exp_rgb = '0;
    exp_q.delete();
    @(negedge clk);
    pcnt = 6'(pc); hend = 13'(he); hsize = 13'(hs); hsync_start = 13'(hss);
    hsync_end = 13'(hse); vend = 13'(ve); vsize = 13'(vs);
    vsync_start = 13'(vss); vsync_end = 13'(vse);
    fif.fifo_empty = 1'b0;
    en = 1'b1;
    for (int n = 0; n <= total + 1; n++) begin
      if (n > 0) @(negedge clk);
      m = n - 1;
      k = (m < 0) ? -1 : (m / p - 1);
      is_tick = (m > 0) && (m % p == 0);
      if (k < 0) begin
        chk("pre_hblank", hblank, 1);
        chk("pre_vblank", vblank, 1);
        chk("pre_rgb", {R, G, B}, 0);
        chk("pre_pulses", {line_start, frame_start}, 0);
      end else begin
        q = k % (he * ve); f = k / (he * ve); h = q % he; v = q / he;
        hsz = (f == 0) ? hs : hs_new;
        act = (h < hsz) && (v < vs);
        if (is_tick) begin
          if (act && !drv_empty) begin
            if (exp_q.size() == 0) chk("sb_empty", 0, 1);
            else exp_rgb = exp_q.pop_front();
            if (q == 0) chk("pix_00", {R, G, B}, 24'hA1B2C3);
          end else begin
            exp_rgb = '0;
          end
          if (act && drv_empty) uf_flag = 1;
        end
        chk("hblank", hblank, (h >= hsz) ? 1 : 0);
        chk("vblank", vblank, (v >= vs) ? 1 : 0);
        chk("hsync", hsync, (h >= hss && h < hse) ? 1 : 0);
        chk("vsync", vsync, (v >= vss && v < vse) ? 1 : 0);
        chk("line_start", line_start, (is_tick && h == 0) ? 1 : 0);
        chk("frame_start", frame_start, (is_tick && q == 0) ? 1 : 0);
        chk("rgb", {R, G, B}, exp_rgb);
        if (frame_start) fs_cnt++;
      end
      if (n > 0) chk("underflow", underflow, uf_flag);
      if (is_tick && k == he + 4) hsize = 13'(hs_new);
      if ((is_tick && k == abort_k) || m == total) en = 1'b0;
      // drive inputs for the next edge; the next tick is k+1
      qn = (k + 1) % (he * ve); fn = (k + 1) / (he * ve);
      hh = qn % he; vv = qn / he;
      hszn = (fn == 0) ? hs : hs_new;
      drv_empty = uf && (fn == 0) && (vv == 0) && (hh == 2 || hh == 3);
      fif.fifo_empty = drv_empty;
      fif.pix_in = (qn == 0) ? 24'hA1B2C3 : 24'($urandom_range(0, 32'h00FF_FFFF));
      #1;
      nt = ((m + 1) > 0) && ((m + 1) % p == 0);
      act_n = (hh < hszn) && (vv < vs);
      exp_rd = en && nt && act_n && !drv_empty;
      chk("fifo_rd", fif.fifo_rd, exp_rd);
      if (exp_rd) exp_q.push_back(fif.pix_in);
      if (fif.fifo_rd) rd_cnt++;
      if (!en) break;
    end
    @(negedge clk);
    chk_idle("stop");
    chk("stop_state", dbg_state, 0);
    chk("stop_underflow", underflow, uf_flag);
    if (abort_k < 0) chk("frame_cnt", fs_cnt, nframes);
    if (abort_k < 0 && !uf && hs_new == hs) chk("rd_cnt", rd_cnt, nframes * hs * vs);
    fif.fifo_empty = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; pcnt = '0;
    hend = 13'd10; hsize = 13'd8; hsync_start = 13'd8; hsync_end = 13'd9;
    vend = 13'd4; vsize = 13'd3; vsync_start = 13'd3; vsync_end = 13'd4;
    fif.fifo_empty = 1'b0; fif.pix_in = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_underflow", underflow, 0);
    chk("reset_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic frame timing, then pixel divider
    run_cfg(0, 10, 8, 8, 9, 4, 3, 3, 4, 8, 2, 1'b0, -1);
    run_cfg(2, 10, 8, 8, 9, 4, 3, 3, 4, 8, 2, 1'b0, -1);
    // underflow at (2,0)-(3,0), hsize 8->6 at (4,1), abort at (5,1) of frame 2
    run_cfg(0, 10, 8, 8, 9, 4, 3, 3, 4, 6, 3, 1'b1, 95);
    // re-entry clears underflow; empty hsync window never asserts
    run_cfg(0, 10, 8, 5, 5, 4, 3, 3, 4, 8, 1, 1'b0, -1);

    // zero line length keeps the block in IDLE
    @(negedge clk);
    hend = 13'd0; en = 1'b1;
    repeat (4) @(negedge clk);
    chk("hend0_state", dbg_state, 0);
    chk_idle("hend0");
    en = 1'b0; hend = 13'd10;
    @(negedge clk);

    // asynchronous reset in the middle of a line
    pcnt = '0; hsize = 13'd8; en = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_hblank", hblank, 0);
    #2 reset = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_state", dbg_state, 0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_timing_out.md
Name: vid_timing_out

Overview:
- Downstream neighbour of the video bus/data-fetch controller.
- Consumes the programmed timing fields (cr.en, cr.pcnt, h1, h2, v1, v2) and the red/green/blue pixel FIFO heads.
- Generates hsync/hblank/vsync/vblank.
- During active display, pops one FIFO entry per pixel tick and drives R/G/B.

Parameters:
- CNT_W, 13: width of horizontal/vertical position counters and timing fields.
- DIV_W, 6: width of the pixel divider field pcnt.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  controller enable (cr.en)
- pcnt  in  DIV_W  pixel divider; one pixel every pcnt+1 clocks
- hend  in  CNT_W  total pixels per line
- hsize  in  CNT_W  displayed pixels per line
- hsync_start  in  CNT_W  first pixel with hsync high
- hsync_end  in  CNT_W  first pixel after hsync
- vend  in  CNT_W  total lines per frame
- vsize  in  CNT_W  displayed lines per frame
- vsync_start  in  CNT_W  first line with vsync high
- vsync_end  in  CNT_W  first line after vsync
- fifo_empty  in  1  pixel FIFOs empty (shared across R/G/B)
- pix_in  in  24  FIFO heads {R[23:16],G[15:8],B[7:0]}; show-ahead, valid while !fifo_empty
- fifo_rd  out  1  pop strobe to all three FIFOs, combinational
- hsync, hblank, vsync, vblank  out  1 each  registered timing outputs
- R, G, B  out  8 each  registered pixel outputs
- line_start  out  1  one-clock pulse when position enters h=0
- frame_start  out  1  one-clock pulse when position enters (0,0)
- underflow  out  1  sticky: displayed pixel needed while FIFO empty

Behaviour:
- Reset (async, reset=1):
  - FSM=IDLE, div_cnt=0, h=0, v=0.
  - hblank=1, vblank=1, hsync=0, vsync=0.
  - R=G=B=0, line_start=0, frame_start=0, underflow=0, shadow registers 0.
- FSM state IDLE:
  - Outputs held at reset values.
  - Every clock: h<=hend-1, v<=vend-1, div_cnt<=0, shadows loaded from the inputs.
- IDLE -> RUN: en=1 and hend!=0 and vend!=0. With en=1 and hend==0 or vend==0, the block stays in IDLE.
- Entering RUN clears underflow.
- Divider:
  - In RUN, div_cnt counts 0..pcnt_sh and wraps to 0.
  - tick = RUN and div_cnt==pcnt_sh.
  - pcnt=0 gives a tick every clock.
- Position advance on tick:
  - h_next = (h==hend_sh-1) ? 0 : h+1.
  - v_next = v+1 on line wrap, wrapping 0 after vend_sh-1; otherwise v_next = v.
  - First tick after entry to RUN lands on (0,0): pcnt+1 clocks after en is seen in IDLE.
- Shadow registers:
  - All timing fields and pcnt are copied into shadows on entry to RUN and on every tick where (h_next,v_next)=(0,0).
  - Input changes therefore take effect only at frame boundaries.
- Outputs registered on tick, from the next position (h_next,v_next):
  - hblank = h_next>=hsize_sh.
  - vblank = v_next>=vsize_sh.
  - hsync = hsync_start_sh<=h_next<hsync_end_sh; never asserted if start>=end.
  - vsync: same rule with the v fields.
  - line_start=1 when h_next=0.
  - frame_start=1 when h_next=0 and v_next=0.
  - Both pulses are 0 on every non-tick clock.
  - All outputs other than line_start/frame_start hold between ticks.
- Pixel path, with disp = tick and h_next<hsize_sh and v_next<vsize_sh:
  - disp and !fifo_empty: fifo_rd=1 for that clock; R/G/B<=pix_in at the same edge.
  - disp and fifo_empty: fifo_rd=0; R/G/B<=0; underflow<=1 (sticky until reset or the next IDLE->RUN).
  - Tick with !disp: R/G/B<=0, fifo_rd=0.
  - fifo_rd is never asserted outside a tick, nor in IDLE.
- en drop in RUN:
  - Next clock goes to IDLE; outputs return to reset values (underflow keeps its value).
  - A partial frame is abandoned and the FIFO is not flushed.
- reset asserted mid-operation: immediate reset values, including fifo_rd=0.
- Width rules: counters are CNT_W unsigned; hend-1/vend-1 are computed only when nonzero; div_cnt is DIV_W bits.

Test Plan:
- Basic frame timing:
  - Config: pcnt=0, hend=10, hsize=8, hsync 8..9, vend=4, vsize=3, vsync 3..4, en=1, FIFO always full.
  - Required: hblank low 8 clocks / high 2 per line; hsync high exactly at h=8.
  - Required: vblank and vsync high for all of line 3; frame_start every 40 clocks; 24 fifo_rd pulses per frame.
- Divider: pcnt=2, same geometry.
  - Required: each position held 3 clocks; fifo_rd is a 1-clock pulse every 3 clocks in active; frame period 120 clocks.
- Underflow:
  - Stimulus: fifo_empty=1 for pixels (2,0)..(3,0).
  - Required: R/G/B=0 and fifo_rd=0 on those ticks; underflow rises at the (2,0) tick and stays 1; it clears only after en toggles 0->1.
- Pixel data: pix_in=24'hA1B2C3 at tick for (0,0).
  - Required: R=A1, G=B2, B=C3 the clock after; all zero during hblank ticks.
- Shadowing:
  - Stimulus: change hsize 8->6 at (4,1).
  - Required: lines 1-2 keep 8 active pixels; the next frame shows 6 active pixels per line.
- Abort and reset:
  - Stimulus: en=0 at (5,1).
  - Required: next clock hblank=vblank=1, RGB=0, fifo_rd=0.
  - Stimulus: async reset pulse mid-line.
  - Required: outputs take reset values without waiting for a clk edge.
